layer_sequencer: RTL and testbench
==================================

Name: layer_sequencer

Overview:
- Sequences one fully-connected layer of neuron instances through a complete inference pass.
- Accepts the input vector from the previous layer, or from the image source, as a valid/ready stream.
- Broadcasts each accepted element to every neuron in the layer as a one-cycle input pulse.
- Collects each neuron's output as its outvalid arrives, then streams the collected layer outputs to the next layer.
- One instance sits between each pair of layers in the network top level.

Parameters:
- NUM_INPUTS, 784, input elements per pass (equals each neuron's num_weight); must be >= 1.
- NUM_NEURONS, 30, neurons in the layer; must be >= 1.
- DATA_WIDTH, 16, width of every data element.

Ports:
- clk  in  1  clock; all logic is on the rising edge.
- rst  in  1  synchronous, active-low reset (rst=0 resets on the next rising clk).
- s_data  in  DATA_WIDTH  input element.
- s_valid  in  1  input element valid.
- s_last  in  1  marks the final element of the input vector.
- s_ready  out  1  sequencer can accept an input element.
- nrn_in_data  out  DATA_WIDTH  element broadcast to all neurons.
- nrn_in_valid  out  1  one-cycle broadcast strobe.
- nrn_out_data  in  NUM_NEURONS*DATA_WIDTH  flat bus; neuron k occupies bits [k*DATA_WIDTH +: DATA_WIDTH].
- nrn_out_valid  in  NUM_NEURONS  per-neuron outvalid pulse.
- m_data  out  DATA_WIDTH  layer output element.
- m_valid  out  1  output element valid.
- m_last  out  1  marks the output element of neuron NUM_NEURONS-1.
- m_ready  in  1  downstream accepts the output element.
- layer_done  out  1  one-cycle pulse when the final output beat is accepted.
- err_framing  out  1  sticky framing error.
- err_spurious  out  1  sticky spurious-outvalid error.

Behaviour:
- Reset (rst=0):
  - State goes to FEED; in_cnt, out_cnt and done_mask clear.
  - All outputs are 0, including s_ready, nrn_in_valid, m_valid, m_last, layer_done and both error flags.
  - Reset applies mid-pass and discards any partially captured data.
  - s_ready rises in the first cycle after rst returns to 1.
- FEED state:
  - s_ready=1.
  - On s_valid & s_ready: nrn_in_data <= s_data and nrn_in_valid <= 1 on the next cycle, held for exactly one cycle (latency 1); in_cnt increments.
  - On the beat with in_cnt==NUM_INPUTS-1, go to WAIT, in_cnt returns to 0, and s_ready drops the following cycle.
  - Back-to-back beats produce back-to-back nrn_in_valid pulses. Gaps in s_valid produce gaps, never repeats.
- Framing check:
  - in_cnt alone defines the vector boundary.
  - err_framing sets if s_last=1 on any non-final beat, or s_last=0 on the final beat.
  - The pass continues unaffected.
- WAIT state:
  - s_ready=0, nrn_in_valid=0.
  - For each bit k with nrn_out_valid[k]=1: capture neuron k's data into out_buf[k] and set done_mask[k].
  - Several bits may assert in the same cycle; all are captured.
  - A repeat pulse from a neuron already in done_mask overwrites out_buf[k] and is not an error.
  - When done_mask is all ones, including bits set in the current cycle, go to DRAIN on the next cycle.
- Spurious outvalid: any nrn_out_valid bit high while in FEED or DRAIN sets err_spurious. That data is ignored.
- DRAIN state:
  - m_valid=1, m_data=out_buf[out_cnt], m_last=(out_cnt==NUM_NEURONS-1).
  - m_data, m_last and m_valid stay stable while m_ready=0.
  - On m_valid & m_ready, out_cnt increments.
  - On the last beat: layer_done pulses for one cycle, done_mask clears, out_cnt returns to 0, and the state returns to FEED. s_ready=1 in the next cycle.
- Counter widths: in_cnt is $clog2(NUM_INPUTS+1) bits; out_cnt is $clog2(NUM_NEURONS+1) bits. No wrap occurs within a pass.
- No arithmetic is performed on data; values pass through bit-exact.
- Error flags stay set until reset.

Decomposition:
- Shared package (nn_pkg), holding:
  - state enum: FEED=2'd0, WAIT=2'd1, DRAIN=2'd2;
  - a localparam function for counter widths.
- Sub-module layer_out_buffer: NUM_NEURONS x DATA_WIDTH register file with a per-bit capture enable, done_mask, all-done flag and an out_cnt-indexed read mux.
- The FSM and counters stay in layer_sequencer.

Test Plan (NUM_INPUTS=4, NUM_NEURONS=3, DATA_WIDTH=16):
- Reset: hold rst=0 for 3 cycles with s_valid=1 -> all outputs 0; s_ready=1 exactly one cycle after rst=1.
- Feed: inputs 0x0001, 0x0002, 0x0003, 0x0004 (s_last on 4th), back-to-back -> four consecutive nrn_in_valid pulses carrying the same values, each 1 cycle later; s_ready=0 after the 4th beat; err_framing=0.
- Capture: outvalid pulses {neuron0, neuron2} together carrying 0x0AAA and 0x0CCC, then neuron1 carrying 0x0BBB 5 cycles later -> DRAIN entered the cycle after neuron1's pulse; m_data sequence 0x0AAA, 0x0BBB, 0x0CCC with m_last on the 3rd; layer_done pulses once.
- Backpressure: hold m_ready=0 for 4 cycles on beat 2 -> m_data stays 0x0BBB with m_valid=1 throughout; no beat is lost or duplicated.
- Errors: s_last on the 2nd beat -> err_framing=1 and the pass still completes; outvalid pulse during FEED -> err_spurious=1 and no capture.
- Mid-pass reset: rst=0 during WAIT with 2 of 3 captured -> returns to FEED; the next full pass outputs only the new values.

Source files
------------

// File: rtl/nn_pkg.sv
// Shared types and sizing helpers for the layer sequencer and its output buffer.
package nn_pkg;

  typedef enum logic [1:0] {
    FEED  = 2'd0,
    WAIT  = 2'd1,
    DRAIN = 2'd2
  } state_e;

  // Width that holds every count 0..n inclusive.
  function automatic int cnt_width(input int n);
    return (n < 1) ? 1 : $clog2(n + 1);
  endfunction

endpackage

// File: rtl/layer_out_buffer.sv
// Per-neuron output capture registers with a done mask and an indexed read port.
// Capture takes effect next cycle; all_done also counts bits captured this cycle.
module layer_out_buffer
  import nn_pkg::*;
#(
  parameter int NUM_NEURONS = 30,
  parameter int DATA_WIDTH  = 16,
  parameter int IDX_W       = cnt_width(NUM_NEURONS)
) (
  input  logic                              clk,
  input  logic                              rst,
  input  logic [NUM_NEURONS-1:0]            cap_en,
  input  logic [NUM_NEURONS*DATA_WIDTH-1:0] cap_data,
  input  logic                              clr,
  input  logic [IDX_W-1:0]                  rd_idx,
  output logic [DATA_WIDTH-1:0]             rd_data,
  output logic                              all_done
);

  logic [DATA_WIDTH-1:0]  buf_q [NUM_NEURONS];
  logic [NUM_NEURONS-1:0] done_q;
  logic [NUM_NEURONS-1:0] done_d;

  assign done_d   = clr ? '0 : (done_q | cap_en);
  assign all_done = &(done_q | cap_en);

  always_ff @(posedge clk) begin
    if (!rst) begin
      done_q <= '0;
      for (int k = 0; k < NUM_NEURONS; k++) buf_q[k] <= '0;
    end else begin
      done_q <= done_d;
      for (int k = 0; k < NUM_NEURONS; k++) begin
        if (cap_en[k]) buf_q[k] <= cap_data[k*DATA_WIDTH +: DATA_WIDTH];
      end
    end
  end

  always_comb begin
    rd_data = '0;
    for (int k = 0; k < NUM_NEURONS; k++) begin
      if (rd_idx == IDX_W'(k)) rd_data = buf_q[k];
    end
  end

endmodule

// File: rtl/layer_sequencer.sv
// Feeds one input vector to a neuron layer, gathers every neuron's result, then streams them out.
// Broadcast latency 1 cycle; input stalls outside FEED, output holds while m_ready is low.
module layer_sequencer
  import nn_pkg::*;
#(
  parameter int NUM_INPUTS  = 784,
  parameter int NUM_NEURONS = 30,
  parameter int DATA_WIDTH  = 16
) (
  input  logic                              clk,
  input  logic                              rst,
  input  logic [DATA_WIDTH-1:0]             s_data,
  input  logic                              s_valid,
  input  logic                              s_last,
  output logic                              s_ready,
  output logic [DATA_WIDTH-1:0]             nrn_in_data,
  output logic                              nrn_in_valid,
  input  logic [NUM_NEURONS*DATA_WIDTH-1:0] nrn_out_data,
  input  logic [NUM_NEURONS-1:0]            nrn_out_valid,
  output logic [DATA_WIDTH-1:0]             m_data,
  output logic                              m_valid,
  output logic                              m_last,
  input  logic                              m_ready,
  output logic                              layer_done,
  output logic                              err_framing,
  output logic                              err_spurious
);

  localparam int INW = cnt_width(NUM_INPUTS);
  localparam int OW  = cnt_width(NUM_NEURONS);

  state_e                  state_q, state_d;
  logic [INW-1:0]          in_cnt_q, in_cnt_d;
  logic [OW-1:0]           out_cnt_q, out_cnt_d;
  logic                    s_ready_q, s_ready_d;
  logic                    nrn_in_valid_q, nrn_in_valid_d;
  logic [DATA_WIDTH-1:0]   nrn_in_data_q, nrn_in_data_d;
  logic                    err_framing_q, err_framing_d;
  logic                    err_spurious_q, err_spurious_d;

  logic                    accept, in_last, out_last, drain_hs, all_done;
  logic [NUM_NEURONS-1:0]  cap_en;
  logic [DATA_WIDTH-1:0]   buf_rd;

  assign accept   = s_valid & s_ready_q;
  assign in_last  = (in_cnt_q == INW'(NUM_INPUTS - 1));
  assign out_last = (out_cnt_q == OW'(NUM_NEURONS - 1));
  assign drain_hs = (state_q == DRAIN) & m_ready;
  assign cap_en   = (state_q == WAIT) ? nrn_out_valid : '0;

  layer_out_buffer #(
    .NUM_NEURONS(NUM_NEURONS),
    .DATA_WIDTH (DATA_WIDTH),
    .IDX_W      (OW)
  ) u_buf (
    .clk     (clk),
    .rst     (rst),
    .cap_en  (cap_en),
    .cap_data(nrn_out_data),
    .clr     (drain_hs & out_last),
    .rd_idx  (out_cnt_q),
    .rd_data (buf_rd),
    .all_done(all_done)
  );

  always_ff @(posedge clk) begin
    if (!rst) begin
      state_q        <= FEED;
      in_cnt_q       <= '0;
      out_cnt_q      <= '0;
      s_ready_q      <= 1'b0;
      nrn_in_valid_q <= 1'b0;
      nrn_in_data_q  <= '0;
      err_framing_q  <= 1'b0;
      err_spurious_q <= 1'b0;
    end else begin
      state_q        <= state_d;
      in_cnt_q       <= in_cnt_d;
      out_cnt_q      <= out_cnt_d;
      s_ready_q      <= s_ready_d;
      nrn_in_valid_q <= nrn_in_valid_d;
      nrn_in_data_q  <= nrn_in_data_d;
      err_framing_q  <= err_framing_d;
      err_spurious_q <= err_spurious_d;
    end
  end

  always_comb begin
    state_d        = state_q;
    in_cnt_d       = in_cnt_q;
    out_cnt_d      = out_cnt_q;
    nrn_in_valid_d = 1'b0;
    nrn_in_data_d  = nrn_in_data_q;
    err_framing_d  = err_framing_q;
    err_spurious_d = err_spurious_q | ((state_q != WAIT) & (|nrn_out_valid));

    case (state_q)
      FEED: begin
        if (accept) begin
          nrn_in_valid_d = 1'b1;
          nrn_in_data_d  = s_data;
          // The beat count, not s_last, decides where the vector ends.
          if (s_last != in_last) err_framing_d = 1'b1;
          if (in_last) begin
            in_cnt_d = '0;
            state_d  = WAIT;
          end else begin
            in_cnt_d = in_cnt_q + INW'(1);
          end
        end
      end
      WAIT: begin
        if (all_done) state_d = DRAIN;
      end
      DRAIN: begin
        if (m_ready) begin
          if (out_last) begin
            out_cnt_d = '0;
            state_d   = FEED;
          end else begin
            out_cnt_d = out_cnt_q + OW'(1);
          end
        end
      end
      default: state_d = FEED;
    endcase

    s_ready_d = (state_d == FEED);
  end

  assign s_ready      = s_ready_q;
  assign nrn_in_valid = nrn_in_valid_q;
  assign nrn_in_data  = nrn_in_data_q;
  assign m_valid      = (state_q == DRAIN);
  assign m_data       = m_valid ? buf_rd : '0;
  assign m_last       = m_valid & out_last;
  assign layer_done   = drain_hs & out_last;
  assign err_framing  = err_framing_q;
  assign err_spurious = err_spurious_q;

endmodule

// File: tb/tb_layer_sequencer.sv
// Directed vector bench for layer_sequencer with 4 inputs, 3 neurons, 16-bit data.
module tb_layer_sequencer;

  localparam int NI = 4;
  localparam int NN = 3;
  localparam int DW = 16;

  logic              clk = 1'b0;
  logic              rst;
  logic [DW-1:0]     s_data;
  logic              s_valid, s_last, s_ready;
  logic [DW-1:0]     nrn_in_data;
  logic              nrn_in_valid;
  logic [NN*DW-1:0]  nrn_out_data;
  logic [NN-1:0]     nrn_out_valid;
  logic [DW-1:0]     m_data;
  logic              m_valid, m_last, m_ready;
  logic              layer_done, err_framing, err_spurious;

  always #5 clk = ~clk;

  layer_sequencer #(.NUM_INPUTS(NI), .NUM_NEURONS(NN), .DATA_WIDTH(DW)) dut (
    .clk          (clk),
    .rst          (rst),
    .s_data       (s_data),
    .s_valid      (s_valid),
    .s_last       (s_last),
    .s_ready      (s_ready),
    .nrn_in_data  (nrn_in_data),
    .nrn_in_valid (nrn_in_valid),
    .nrn_out_data (nrn_out_data),
    .nrn_out_valid(nrn_out_valid),
    .m_data       (m_data),
    .m_valid      (m_valid),
    .m_last       (m_last),
    .m_ready      (m_ready),
    .layer_done   (layer_done),
    .err_framing  (err_framing),
    .err_spurious (err_spurious)
  );

  typedef struct packed {
    logic          srdy;
    logic          niv;
    logic [DW-1:0] nid;
    logic          mv;
    logic [DW-1:0] md;
    logic          ml;
    logic          done;
    logic          ef;
    logic          es;
  } out_t;

  typedef struct packed {
    logic             rst;
    logic             sv;
    logic [DW-1:0]    sd;
    logic             sl;
    logic [NN-1:0]    nov;
    logic [NN*DW-1:0] nod;
    logic             mr;
    out_t             exp;
  } vec_t;

  vec_t  vecs[$];
  string names[$];
  int    vec_cnt  = 0;
  int    miss_cnt = 0;

  task automatic add(input string nm, input logic r, input logic sv, input logic [DW-1:0] sd,
                     input logic sl, input logic [NN-1:0] nov, input logic [NN*DW-1:0] nod,
                     input logic mr, input logic srdy, input logic niv, input logic [DW-1:0] nid,
                     input logic mv, input logic [DW-1:0] md, input logic ml, input logic dn,
                     input logic ef, input logic es);
    vec_t v;
    v.rst = r; v.sv = sv; v.sd = sd; v.sl = sl; v.nov = nov; v.nod = nod; v.mr = mr;
    v.exp = '{srdy: srdy, niv: niv, nid: nid, mv: mv, md: md, ml: ml, done: dn, ef: ef, es: es};
    vecs.push_back(v);
    names.push_back(nm);
  endtask

  task automatic check(input string nm, input logic [31:0] got, input logic [31:0] exp);
    vec_cnt++;
    if (got !== exp) begin
      miss_cnt++;
      $display("FAIL %s: got %h expected %h", nm, got, exp);
    end
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish in time");
    $fatal(1, "watchdog");
  end

  initial begin
    out_t got, exp;
    int   k, j;
    rst = 1'b0; s_valid = 1'b0; s_data = '0; s_last = 1'b0;
    nrn_out_valid = '0; nrn_out_data = '0; m_ready = 1'b1;

    // name rst sv sd sl nov nod mr | srdy niv nid mv md ml done ef es
    for (int i = 0; i < 3; i++)
      add("reset",     0,1,16'h0001,0,3'b000,48'h0,1, 0,0,16'h0,0,16'h0,0,0,0,0);
    add("rst_release", 1,1,16'h0001,0,3'b000,48'h0,1, 0,0,16'h0,0,16'h0,0,0,0,0);
    add("feed0",       1,1,16'h0001,0,3'b000,48'h0,1, 1,0,16'h0,0,16'h0,0,0,0,0);
    add("feed1",       1,1,16'h0002,0,3'b000,48'h0,1, 1,1,16'h0001,0,16'h0,0,0,0,0);
    add("feed2",       1,1,16'h0003,0,3'b000,48'h0,1, 1,1,16'h0002,0,16'h0,0,0,0,0);
    add("feed3",       1,1,16'h0004,1,3'b000,48'h0,1, 1,1,16'h0003,0,16'h0,0,0,0,0);
    add("wait_entry",  1,0,16'h0000,0,3'b000,48'h0,1, 0,1,16'h0004,0,16'h0,0,0,0,0);
    add("cap_n0n2",    1,0,16'h0000,0,3'b101,{16'h0CCC,16'h0000,16'h0AAA},1, 0,0,16'h0,0,16'h0,0,0,0,0);
    for (int i = 0; i < 4; i++)
      add("wait_idle", 1,0,16'h0000,0,3'b000,48'h0,1, 0,0,16'h0,0,16'h0,0,0,0,0);
    add("cap_n1",      1,0,16'h0000,0,3'b010,{16'h0000,16'h0BBB,16'h0000},1, 0,0,16'h0,0,16'h0,0,0,0,0);
    add("drain0",      1,0,16'h0000,0,3'b000,48'h0,1, 0,0,16'h0,1,16'h0AAA,0,0,0,0);
    for (int i = 0; i < 4; i++)
      add("hold_beat1",1,0,16'h0000,0,3'b000,48'h0,0, 0,0,16'h0,1,16'h0BBB,0,0,0,0);
    add("drain1",      1,0,16'h0000,0,3'b000,48'h0,1, 0,0,16'h0,1,16'h0BBB,0,0,0,0);
    add("drain2_last", 1,0,16'h0000,0,3'b000,48'h0,1, 0,0,16'h0,1,16'h0CCC,1,1,0,0);
    add("back_feed",   1,0,16'h0000,0,3'b000,48'h0,1, 1,0,16'h0,0,16'h0,0,0,0,0);
    // framing error on the second beat plus a spurious outvalid during FEED
    add("e_feed0",     1,1,16'h0011,0,3'b000,48'h0,1, 1,0,16'h0,0,16'h0,0,0,0,0);
    add("e_feed1",     1,1,16'h0012,1,3'b001,{16'h0000,16'h0000,16'hDEAD},1, 1,1,16'h0011,0,16'h0,0,0,0,0);
    add("e_feed2",     1,1,16'h0013,0,3'b000,48'h0,1, 1,1,16'h0012,0,16'h0,0,0,1,1);
    add("e_feed3",     1,1,16'h0014,1,3'b000,48'h0,1, 1,1,16'h0013,0,16'h0,0,0,1,1);
    add("e_cap_n1n2",  1,0,16'h0000,0,3'b110,{16'h0303,16'h0202,16'h0000},1, 0,1,16'h0014,0,16'h0,0,0,1,1);
    add("e_cap_n0n1",  1,0,16'h0000,0,3'b011,{16'h0000,16'h0222,16'h0101},1, 0,0,16'h0,0,16'h0,0,0,1,1);
    add("e_drain0",    1,0,16'h0000,0,3'b000,48'h0,1, 0,0,16'h0,1,16'h0101,0,0,1,1);
    add("e_drain1",    1,0,16'h0000,0,3'b000,48'h0,1, 0,0,16'h0,1,16'h0222,0,0,1,1);
    add("e_drain2",    1,0,16'h0000,0,3'b000,48'h0,1, 0,0,16'h0,1,16'h0303,1,1,1,1);
    add("e_sticky",    1,0,16'h0000,0,3'b000,48'h0,1, 1,0,16'h0,0,16'h0,0,0,1,1);
    // reset while waiting with two of three results captured
    add("m_feed0",     1,1,16'h0021,0,3'b000,48'h0,1, 1,0,16'h0,0,16'h0,0,0,1,1);
    add("m_feed1",     1,1,16'h0022,0,3'b000,48'h0,1, 1,1,16'h0021,0,16'h0,0,0,1,1);
    add("m_feed2",     1,1,16'h0023,0,3'b000,48'h0,1, 1,1,16'h0022,0,16'h0,0,0,1,1);
    add("m_feed3",     1,1,16'h0024,1,3'b000,48'h0,1, 1,1,16'h0023,0,16'h0,0,0,1,1);
    add("m_cap_n0n1",  1,0,16'h0000,0,3'b011,{16'h0000,16'h0E1E,16'h0E0E},1, 0,1,16'h0024,0,16'h0,0,0,1,1);
    add("m_rst_assert",0,0,16'h0000,0,3'b000,48'h0,1, 0,0,16'h0,0,16'h0,0,0,1,1);
    add("m_rst_applied",1,0,16'h0000,0,3'b000,48'h0,1, 0,0,16'h0,0,16'h0,0,0,0,0);
    add("n_feed0",     1,1,16'h0031,0,3'b000,48'h0,1, 1,0,16'h0,0,16'h0,0,0,0,0);
    add("n_feed1",     1,1,16'h0032,0,3'b000,48'h0,1, 1,1,16'h0031,0,16'h0,0,0,0,0);
    add("n_feed2",     1,1,16'h0033,0,3'b000,48'h0,1, 1,1,16'h0032,0,16'h0,0,0,0,0);
    add("n_feed3",     1,1,16'h0034,1,3'b000,48'h0,1, 1,1,16'h0033,0,16'h0,0,0,0,0);
    add("n_cap_n2",    1,0,16'h0000,0,3'b100,{16'h0C3C,16'h0000,16'h0000},1, 0,1,16'h0034,0,16'h0,0,0,0,0);
    add("n_cap_n0n1",  1,0,16'h0000,0,3'b011,{16'h0000,16'h0B3B,16'h0A3A},1, 0,0,16'h0,0,16'h0,0,0,0,0);
    add("n_drain0",    1,0,16'h0000,0,3'b000,48'h0,1, 0,0,16'h0,1,16'h0A3A,0,0,0,0);
    add("n_drain1",    1,0,16'h0000,0,3'b000,48'h0,1, 0,0,16'h0,1,16'h0B3B,0,0,0,0);
    add("n_drain2",    1,0,16'h0000,0,3'b000,48'h0,1, 0,0,16'h0,1,16'h0C3C,1,1,0,0);
    add("n_idle",      1,0,16'h0000,0,3'b000,48'h0,1, 1,0,16'h0,0,16'h0,0,0,0,0);

    for (int i = 0; i < vecs.size(); i++) begin
      @(posedge clk); #1;
      rst = vecs[i].rst; s_valid = vecs[i].sv; s_data = vecs[i].sd; s_last = vecs[i].sl;
      nrn_out_valid = vecs[i].nov; nrn_out_data = vecs[i].nod; m_ready = vecs[i].mr;
      @(negedge clk);
      exp = vecs[i].exp;
      got = '{srdy: s_ready, niv: nrn_in_valid, nid: nrn_in_data, mv: m_valid, md: m_data,
              ml: m_last, done: layer_done, ef: err_framing, es: err_spurious};
      if (!exp.niv) got.nid = exp.nid;
      if (!exp.mv) begin got.md = exp.md; got.ml = exp.ml; end
      vec_cnt++;
      if (got !== exp) begin
        miss_cnt++;
        $display("FAIL vec %0d %s: got srdy=%b niv=%b nid=%h mv=%b md=%h ml=%b done=%b ef=%b es=%b expected srdy=%b niv=%b nid=%h mv=%b md=%h ml=%b done=%b ef=%b es=%b",
                 i, names[i], got.srdy, got.niv, got.nid, got.mv, got.md, got.ml, got.done, got.ef, got.es,
                 exp.srdy, exp.niv, exp.nid, exp.mv, exp.md, exp.ml, exp.done, exp.ef, exp.es);
      end
    end

    // Gapped input: one broadcast per accepted beat, never a repeat.
    k = 0;
    for (int c = 0; c < 12; c++) begin
      @(posedge clk); #1;
      s_valid = (c < 8) && (c % 2 == 0);
      s_data  = 16'h0040 + 16'(c / 2);
      s_last  = (c == 6);
      nrn_out_valid = '0; m_ready = 1'b0;
      @(negedge clk);
      if (nrn_in_valid) begin
        check("gap_bcast_data", 32'(nrn_in_data), 32'h40 + 32'(k));
        k++;
      end
    end
    check("gap_bcast_count", 32'(k), 32'd4);
    check("gap_no_framing", 32'(err_framing), 32'd0);

    @(posedge clk); #1;
    s_valid = 1'b0;
    nrn_out_valid = 3'b111; nrn_out_data = {16'h5002, 16'h5001, 16'h5000};
    @(negedge clk);

    // Drain with alternating m_ready; bounded wait for the final beat.
    j = 0;
    for (int c = 0; c < 30 && j < 3; c++) begin
      @(posedge clk); #1;
      nrn_out_valid = '0; nrn_out_data = '0;
      m_ready = c[0];
      @(negedge clk);
      if (m_valid && m_ready) begin
        check("alt_drain_data", 32'(m_data), 32'h5000 + 32'(j));
        check("alt_drain_last", 32'(m_last), 32'(j == 2));
        check("alt_drain_done", 32'(layer_done), 32'(j == 2));
        j++;
      end
    end
    check("alt_drain_beats", 32'(j), 32'd3);

    @(posedge clk); #1;
    m_ready = 1'b0;
    @(negedge clk);
    check("alt_back_to_feed", 32'({s_ready, m_valid, err_spurious}), 32'b100);

    $display("== %0d vectors applied, %0d miscompares ==", vec_cnt, miss_cnt);
    $finish;
  end

endmodule
